// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampled UART receiver and transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   localparam int CLK_FREQ  = 1000000;
   localparam int BAUD_RATE = 9600;
   localparam int OS_RATE   = 16;
   localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick: one-clk pulse every clk_freq/(baud_rate*os_rate) clocks.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int clk_freq  = CLK_FREQ,
   parameter int baud_rate = BAUD_RATE,
   parameter int os_rate   = OS_RATE
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int tick_div = clk_freq / (baud_rate * os_rate);
   localparam int cw       = (tick_div > 1) ? $clog2(tick_div) : 1;
   localparam logic [cw-1:0] last = cw'(tick_div - 1);

   if (tick_div < 1) begin : g_bad_div
      $error("uart_baud_tick: clk_freq too low for baud_rate*os_rate");
   end

   logic [cw-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == last)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == last);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8N1 UART receiver with mid-bit sampling, false-start
// rejection, framing-error detection and a one-byte valid/ready output.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int clk_freq  = CLK_FREQ,
   parameter int baud_rate = BAUD_RATE,
   parameter int os_rate   = OS_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int ow = $clog2(os_rate);
   localparam logic [ow-1:0] os_half  = ow'(os_rate / 2 - 1);
   localparam logic [ow-1:0] os_last  = ow'(os_rate - 1);
   localparam logic [2:0]    last_bit = 3'(DATA_BITS - 1);

   if (os_rate < 4 || (os_rate % 2) != 0) begin : g_bad_os
      $error("uart_rx_os16: os_rate must be even and >= 4");
   end

   logic                 tick;
   logic                 rx_m, rx_s;
   state_t               state, state_n;
   logic [ow-1:0]        os_cnt, os_n;
   logic [2:0]           bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shift_r, shift_n;
   logic                 byte_done, ferr;
   logic                 accept;

   uart_baud_tick #(
      .clk_freq (clk_freq),
      .baud_rate(baud_rate),
      .os_rate  (os_rate)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Sync flops reset high so a reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_comb begin
      state_n   = state;
      os_n      = os_cnt;
      bit_n     = bit_cnt;
      shift_n   = shift_r;
      byte_done = 1'b0;
      ferr      = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               os_n    = '0;
            end
         end
         START: begin
            if (tick) begin
               if (os_cnt == os_half) begin
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     os_n    = '0;
                     bit_n   = '0;
                     state_n = DATA;
                  end
               end else begin
                  os_n = os_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (os_cnt == os_last) begin
                  shift_n = {rx_s, shift_r[DATA_BITS-1:1]};
                  os_n    = '0;
                  bit_n   = bit_cnt + 1'b1;
                  if (bit_cnt == last_bit)
                     state_n = STOP;
               end else begin
                  os_n = os_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (os_cnt == os_last) begin
                  if (rx_s) begin
                     byte_done = 1'b1;
                     state_n   = IDLE;
                  end else begin
                     ferr    = 1'b1;
                     state_n = WAIT_HIGH;
                  end
               end else begin
                  os_n = os_cnt + 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept = rx_valid & rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         os_cnt    <= '0;
         bit_cnt   <= '0;
         shift_r   <= '0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         os_cnt    <= os_n;
         bit_cnt   <= bit_n;
         shift_r   <= shift_n;
         frame_err <= ferr;
         overrun   <= byte_done & rx_valid & ~accept;
         // An accept in the completion clk frees the slot for the new byte.
         if (byte_done && (!rx_valid || accept)) begin
            rx_data  <= shift_r;
            rx_valid <= 1'b1;
         end else if (accept) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of clean/bad frames plus corner sequences.
module tb_uart_rx_os16;

   localparam int BIT = 160;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_os16 #(
      .clk_freq (1600000),
      .baud_rate(10000),
      .os_rate  (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, hi_cnt = 0, lo_cnt = 0;
   int   ovr_cyc = 0, rise_cyc = 0;
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      ferr_cnt <= ferr_cnt + int'(frame_err);
      ovr_cnt  <= ovr_cnt + int'(overrun);
      busy_cnt <= busy_cnt + int'(busy);
      hi_cnt   <= hi_cnt + int'(rx_valid);
      lo_cnt   <= lo_cnt + int'(!rx_valid);
      if (overrun) ovr_cyc <= cyc;
      if (rx_valid && !prev_valid) rise_cyc <= cyc;
      prev_valid <= rx_valid;
   end

   int errors = 0;
   int checks = 0;
   int last_start = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called and returns at #1 after a posedge.
   task automatic drive(input logic b, input int n);
      rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len);
      last_start = cyc;
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(d[i], BIT);
      drive(stop_bit, stop_len);
      rx = 1'b1;
   endtask

   task automatic accept_one();
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int f0, o0, b0, h0, l0, lat, d4, aa4_start, s5, s6, target;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1};
      vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};

      rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", rx_valid, 0);
      chk("reset_data", rx_data, 0);
      chk("reset_ferr", frame_err, 0);
      chk("reset_ovr", overrun, 0);
      chk("reset_busy", busy, 0);
      @(posedge clk); #1;
      drive(1'b1, 20);

      // Table: clean frames and a single bad stop bit
      for (int i = 0; i < 5; i++) begin
         f0 = ferr_cnt; o0 = ovr_cnt;
         send_frame(vecs[i].data, vecs[i].stop, BIT);
         drive(1'b1, 100);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
         chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
         chk($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
         chk($sformatf("vec%0d_busy", i), busy, 0);
         if (vecs[i].exp_valid) begin
            lat = rise_cyc - last_start;
            chk($sformatf("vec%0d_latency_in_1500_1530", i), (lat >= 1500 && lat <= 1530), 1);
            @(posedge clk); #1;
            accept_one();
            @(negedge clk);
            chk($sformatf("vec%0d_valid_after_accept", i), rx_valid, 0);
         end
         @(posedge clk); #1;
      end

      // False start: 50-clk glitch
      f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
      drive(1'b0, 50);
      drive(1'b1, 300);
      @(negedge clk);
      chk("glitch_valid", rx_valid, 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);
      chk("glitch_ovr", ovr_cnt - o0, 0);
      chk("glitch_busy_lt90", (busy_cnt - b0) < 90, 1);
      chk("glitch_busy_seen", (busy_cnt - b0) > 0, 1);
      chk("glitch_busy_now", busy, 0);
      @(posedge clk); #1;

      // Break: bad stop held low for 400 clk, then a clean frame
      f0 = ferr_cnt; h0 = hi_cnt;
      send_frame(8'h3C, 1'b0, 400);
      drive(1'b1, 200);
      @(negedge clk);
      chk("break_ferr_once", ferr_cnt - f0, 1);
      chk("break_valid_never", hi_cnt - h0, 0);
      @(posedge clk); #1;
      send_frame(8'h81, 1'b1, BIT);
      drive(1'b1, 100);
      @(negedge clk);
      chk("after_break_data", rx_data, 8'h81);
      chk("after_break_valid", rx_valid, 1);
      chk("after_break_ferr", ferr_cnt - f0, 1);
      @(posedge clk); #1;
      accept_one();

      // Overrun: back-to-back 0x55, 0xAA with no accept
      drive(1'b1, 50);
      o0 = ovr_cnt;
      send_frame(8'h55, 1'b1, BIT);
      aa4_start = cyc;
      send_frame(8'hAA, 1'b1, BIT);
      drive(1'b1, 100);
      @(negedge clk);
      d4 = ovr_cyc - aa4_start;
      chk("ovr_pulse_once", ovr_cnt - o0, 1);
      chk("ovr_data_kept", rx_data, 8'h55);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_at_stop_sample", (d4 >= 1500 && d4 <= 1530), 1);
      @(posedge clk); #1;
      accept_one();
      @(negedge clk);
      chk("ovr_valid_after_accept", rx_valid, 0);
      @(posedge clk); #1;

      // Accept in the completion clk of 0xAA; tick phase realigned to the overrun run
      drive(1'b1, 50);
      while (((cyc - aa4_start) % 10) != 0) begin
         @(posedge clk); #1;
      end
      o0 = ovr_cnt;
      s5 = cyc;
      target = s5 + 1600 + d4 - 1;
      fork
         begin
            send_frame(8'h55, 1'b1, BIT);
            send_frame(8'hAA, 1'b1, BIT);
         end
         begin
            while (cyc < s5 + 1600) begin
               @(posedge clk); #1;
            end
            l0 = lo_cnt;
            while (cyc < target) begin
               @(posedge clk); #1;
            end
            accept_one();
         end
      join
      drive(1'b1, 100);
      @(negedge clk);
      chk("same_clk_data", rx_data, 8'hAA);
      chk("same_clk_valid", rx_valid, 1);
      chk("same_clk_no_ovr", ovr_cnt - o0, 0);
      chk("same_clk_valid_held", lo_cnt - l0, 0);
      @(posedge clk); #1;

      // Reset during data bit 4 of 0xF0, then a clean 0x0F
      drive(1'b1, 50);
      s6 = cyc;
      fork
         send_frame(8'hF0, 1'b1, BIT);
         begin
            while (cyc < s6 + 5 * BIT + 80) begin
               @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("midrst_valid", rx_valid, 0);
            chk("midrst_data", rx_data, 0);
            chk("midrst_ferr", frame_err, 0);
            chk("midrst_ovr", overrun, 0);
            chk("midrst_busy", busy, 0);
         end
      join
      drive(1'b1, 200);
      f0 = ferr_cnt;
      send_frame(8'h0F, 1'b1, BIT);
      drive(1'b1, 100);
      @(negedge clk);
      chk("post_rst_data", rx_data, 8'h0F);
      chk("post_rst_valid", rx_valid, 1);
      chk("post_rst_ferr", ferr_cnt - f0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
